// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers and flag reset values for the dual-clock FIFO
//
// Purpose: gray/binary conversion used by both FIFO pointer controllers, the
//          default address width and the reset values of the status flags.
// Ports:   none (package).
package fifo_pkg;

  // Default RAM address width; controllers use PTR_W = ADDR_W + 1 so the
  // extra MSB acts as the wrap bit that tells full from empty.
  localparam int DEFAULT_ADDR_W = 4;
  localparam int MAX_PTR_W      = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_word_t;

  // Flag values held while the controller is in reset.
  localparam logic EMPTY_RST     = 1'b1;
  localparam logic AEMPTY_RST    = 1'b1;
  localparam logic UNDERFLOW_RST = 1'b0;
  localparam logic RD_VALID_RST  = 1'b0;

  // Width-generic conversions: callers zero-extend into a ptr_word_t and
  // truncate the result back to their own pointer width.  Upper zero bits do
  // not disturb the lower bits in either direction.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - generic N-stage flop synchroniser for gray-coded pointers
//
// Purpose: carries a gray pointer from a foreign clock domain into the local
//          one through STAGES back-to-back flops with no logic in between.
// Ports:
//   clk_i    in   local clock
//   rst_n_i  in   asynchronous active-low reset, clears every stage
//   d_i      in   WIDTH  pointer from the other domain
//   q_o      out  WIDTH  synchronised pointer (last stage)
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side pointer and flag controller for the dual-clock FIFO
//
// Purpose: owns the read pointer, synchronises the write pointer into the
//          read clock domain and produces registered empty/almost_empty,
//          fill level, sticky underflow and a one-cycle read-valid strobe.
// Ports:
//   rdclk         in   read-domain clock
//   rdrst_n       in   asynchronous active-low reset
//   rden          in   read request
//   wr_ptr_gray   in   ADDR_W+1  gray write pointer from the write domain
//   uf_clr        in   clears sticky underflow
//   rd_addr       out  ADDR_W    binary RAM read address
//   rd_ptr_gray   out  ADDR_W+1  registered gray read pointer to write domain
//   rd_valid      out  RAM data valid (one cycle after an accepted read)
//   empty         out  FIFO empty
//   almost_empty  out  level <= AE_THRESH
//   rd_level      out  ADDR_W+1  occupancy seen from the read side, 0..DEPTH
//   underflow     out  sticky: read attempted while empty
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rdclk,
  input  logic              rdrst_n,
  input  logic              rden,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  input  logic              uf_clr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wg_s;
  logic [PTR_W-1:0] wb_s;

  logic [PTR_W-1:0] rd_bin_q,  rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic [PTR_W-1:0] level_q,   level_d;
  logic             empty_q,   empty_d;
  logic             aempty_q,  aempty_d;
  logic             uf_q,      uf_d;
  logic             rvalid_q,  rvalid_d;
  logic             rd_fire;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_i   (rdclk),
    .rst_n_i (rdrst_n),
    .d_i     (wr_ptr_gray),
    .q_o     (wg_s)
  );

  assign wb_s = PTR_W'(gray2bin(ptr_word_t'(wg_s)));

  // Acceptance uses the registered empty flag only, so a read can never be
  // granted on a word whose write has not yet crossed the synchroniser.
  assign rd_fire = rden & ~empty_q;

  always_comb begin
    rd_bin_d  = rd_bin_q + {{ADDR_W{1'b0}}, rd_fire};
    rd_gray_d = PTR_W'(bin2gray(ptr_word_t'(rd_bin_d)));
    // Modular difference: equal low bits with differing wrap bits yields DEPTH.
    level_d   = wb_s - rd_bin_d;
    // Looking at the post-read pointer lets the last read raise empty on the
    // same edge that consumes the word.
    empty_d   = (rd_gray_d == wg_s);
    aempty_d  = (level_d <= PTR_W'(AE_THRESH));
    rvalid_d  = rd_fire;
    // Set dominates clear so an underflow in the clearing cycle is not lost.
    uf_d      = (uf_q & ~uf_clr) | (rden & empty_q);
  end

  always_ff @(posedge rdclk or negedge rdrst_n) begin
    if (!rdrst_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      level_q   <= '0;
      empty_q   <= EMPTY_RST;
      aempty_q  <= AEMPTY_RST;
      uf_q      <= UNDERFLOW_RST;
      rvalid_q  <= RD_VALID_RST;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      uf_q      <= uf_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign rd_addr      = rd_bin_q[ADDR_W-1:0];
  assign rd_ptr_gray  = rd_gray_q;
  assign rd_valid     = rvalid_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign rd_level     = level_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  logic       rdclk = 1'b0;
  logic       rdrst_n;
  logic       rden;
  logic [4:0] wr_ptr_gray;
  logic       uf_clr;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       underflow;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_rd_ctrl #(
    .ADDR_W      (4),
    .SYNC_STAGES (2),
    .AE_THRESH   (2)
  ) dut (
    .rdclk        (rdclk),
    .rdrst_n      (rdrst_n),
    .rden         (rden),
    .wr_ptr_gray  (wr_ptr_gray),
    .uf_clr       (uf_clr),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  always #5 rdclk = ~rdclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rdclk);
  endtask

  // Checks every output against the reset values.
  task automatic chk_reset(input string tag);
    chk({tag, "_empty"},  32'(empty),        32'd1);
    chk({tag, "_ae"},     32'(almost_empty), 32'd1);
    chk({tag, "_level"},  32'(rd_level),     32'd0);
    chk({tag, "_gray"},   32'(rd_ptr_gray),  32'd0);
    chk({tag, "_uf"},     32'(underflow),    32'd0);
    chk({tag, "_rvalid"}, 32'(rd_valid),     32'd0);
    chk({tag, "_addr"},   32'(rd_addr),      32'd0);
  endtask

  initial begin
    rdrst_n     = 1'b0;
    rden        = 1'b0;
    uf_clr      = 1'b0;
    wr_ptr_gray = 5'b00011;

    // Reset with a non-zero write pointer present.
    tick(2);
    chk_reset("rst");
    rdrst_n = 1'b1;
    tick(1);
    chk("rel_e1_empty", 32'(empty), 32'd1);
    tick(1);
    chk("rel_e2_empty", 32'(empty), 32'd1);
    tick(1);
    chk("rel_e3_empty", 32'(empty), 32'd0);
    chk("rel_e3_level", 32'(rd_level), 32'd2);
    chk("rel_e3_ae", 32'(almost_empty), 32'd1);

    // Single word: restart from a clean zero pointer.
    rdrst_n = 1'b0;
    wr_ptr_gray = 5'b00000;
    tick(1);
    rdrst_n = 1'b1;
    tick(3);
    chk("sw_idle_empty", 32'(empty), 32'd1);
    wr_ptr_gray = 5'b00001;
    tick(2);
    chk("sw_e2_empty", 32'(empty), 32'd1);
    tick(1);
    chk("sw_e3_empty", 32'(empty), 32'd0);
    chk("sw_level", 32'(rd_level), 32'd1);
    rden = 1'b1;
    chk("sw_addr", 32'(rd_addr), 32'd0);
    tick(1);
    rden = 1'b0;
    chk("sw_empty_after", 32'(empty), 32'd1);
    chk("sw_gray", 32'(rd_ptr_gray), 32'b00001);
    chk("sw_rvalid", 32'(rd_valid), 32'd1);
    chk("sw_level0", 32'(rd_level), 32'd0);
    tick(1);
    chk("sw_rvalid_drop", 32'(rd_valid), 32'd0);

    // Full drain of 16 words: write pointer at binary 16 (gray 11000).
    rdrst_n = 1'b0;
    wr_ptr_gray = 5'b00000;
    tick(1);
    rdrst_n = 1'b1;
    wr_ptr_gray = 5'b11000;
    tick(3);
    chk("fd_full_level", 32'(rd_level), 32'd16);
    chk("fd_full_ae", 32'(almost_empty), 32'd0);
    rden = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fd_addr%0d", i), 32'(rd_addr), 32'(i));
      chk($sformatf("fd_level%0d", i), 32'(rd_level), 32'(16 - i));
      chk($sformatf("fd_empty%0d", i), 32'(empty), 32'd0);
      tick(1);
    end
    rden = 1'b0;
    chk("fd_end_empty", 32'(empty), 32'd1);
    chk("fd_end_level", 32'(rd_level), 32'd0);
    chk("fd_end_gray", 32'(rd_ptr_gray), 32'b11000);
    chk("fd_end_rvalid", 32'(rd_valid), 32'd1);

    // Second drain across the 31 -> 0 wrap: write pointer binary 32 == 0.
    wr_ptr_gray = 5'b00000;
    tick(3);
    chk("wr_full_level", 32'(rd_level), 32'd16);
    chk("wr_full_empty", 32'(empty), 32'd0);
    rden = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wr_addr%0d", i), 32'(rd_addr), 32'(i));
      chk($sformatf("wr_level%0d", i), 32'(rd_level), 32'(16 - i));
      chk($sformatf("wr_empty%0d", i), 32'(empty), 32'd0);
      tick(1);
    end
    rden = 1'b0;
    chk("wr_end_empty", 32'(empty), 32'd1);
    chk("wr_end_gray", 32'(rd_ptr_gray), 32'b00000);

    // almost_empty: 5 words (gray of 5 is 00111), read one per cycle.
    wr_ptr_gray = 5'b00111;
    tick(3);
    chk("ae_l5_level", 32'(rd_level), 32'd5);
    chk("ae_l5_ae", 32'(almost_empty), 32'd0);
    rden = 1'b1;
    tick(1);
    chk("ae_l4", 32'(almost_empty), 32'd0);
    tick(1);
    chk("ae_l3", 32'(almost_empty), 32'd0);
    tick(1);
    chk("ae_l2_level", 32'(rd_level), 32'd2);
    chk("ae_l2", 32'(almost_empty), 32'd1);
    tick(1);
    chk("ae_l1", 32'(almost_empty), 32'd1);
    tick(1);
    chk("ae_l0", 32'(almost_empty), 32'd1);
    chk("ae_l0_empty", 32'(empty), 32'd1);
    chk("ae_l0_uf", 32'(underflow), 32'd0);

    // Underflow: rden stays high while empty for three edges.
    tick(1);
    chk("uf1_flag", 32'(underflow), 32'd1);
    chk("uf1_rvalid", 32'(rd_valid), 32'd0);
    chk("uf1_addr", 32'(rd_addr), 32'd5);
    tick(2);
    chk("uf3_flag", 32'(underflow), 32'd1);
    chk("uf3_addr", 32'(rd_addr), 32'd5);
    chk("uf3_gray", 32'(rd_ptr_gray), 32'b00111);
    chk("uf3_rvalid", 32'(rd_valid), 32'd0);
    uf_clr = 1'b1;
    tick(1);
    chk("uf_setclr", 32'(underflow), 32'd1);
    rden = 1'b0;
    tick(1);
    uf_clr = 1'b0;
    chk("uf_clr", 32'(underflow), 32'd0);

    // Reset mid-drain: 7 words (binary 12, gray 01010), reset between edges.
    wr_ptr_gray = 5'b01010;
    tick(3);
    chk("md_level", 32'(rd_level), 32'd7);
    rden = 1'b1;
    tick(1);
    chk("md_level6", 32'(rd_level), 32'd6);
    chk("md_rvalid", 32'(rd_valid), 32'd1);
    #2;
    rdrst_n = 1'b0;
    #1;
    chk_reset("md");
    rden = 1'b0;
    tick(2);
    chk_reset("md_held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
